// File: rtl/spi_ram_ctrl.sv
// Command decoder and single-port RAM behind the SPI slave.
// Executes WR_ADDR / WR_DATA / RD_ADDR / RD_DATA frames and returns read bytes on tx_data.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       cmd_err
);

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } opcode_t;

   logic [7:0]           mem [MEM_DEPTH];
   logic                 rx_valid_q;
   logic                 accept;
   opcode_t              opcode;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic                 wr_addr_vld;
   logic                 rd_addr_vld;
   logic                 do_write;
   logic                 do_read;
   logic [7:0]           rd_q;
   logic                 rd_q_vld;

   // A level held across several cycles yields one command; rx_valid_q resets low so a
   // level already present at reset release counts as a fresh edge.
   assign accept   = rx_valid & ~rx_valid_q;
   assign opcode   = opcode_t'(rx_data[9:8]);
   assign do_write = accept && (opcode == OP_WR_DATA) && wr_addr_vld;
   assign do_read  = accept && (opcode == OP_RD_DATA) && rd_addr_vld;

   // Storage and read data are deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_addr] <= rx_data[7:0];
      if (do_read)  rd_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid_q  <= 1'b0;
         wr_addr     <= '0;
         rd_addr     <= '0;
         wr_addr_vld <= 1'b0;
         rd_addr_vld <= 1'b0;
         rd_q_vld    <= 1'b0;
         tx_valid    <= 1'b0;
         tx_data     <= 8'h00;
         cmd_err     <= 1'b0;
      end else begin
         rx_valid_q <= rx_valid;
         cmd_err    <= 1'b0;
         rd_q_vld   <= do_read;
         tx_valid   <= rd_q_vld;
         if (rd_q_vld) tx_data <= rd_q;

         if (accept) begin
            unique case (opcode)
               OP_WR_ADDR: begin
                  wr_addr     <= rx_data[ADDR_SIZE-1:0];
                  wr_addr_vld <= 1'b1;
               end
               OP_WR_DATA: begin
                  if (wr_addr_vld) wr_addr <= wr_addr + ADDR_SIZE'(1);
                  else             cmd_err <= 1'b1;
               end
               OP_RD_ADDR: begin
                  rd_addr     <= rx_data[ADDR_SIZE-1:0];
                  rd_addr_vld <= 1'b1;
               end
               OP_RD_DATA: begin
                  if (rd_addr_vld) rd_addr <= rd_addr + ADDR_SIZE'(1);
                  else             cmd_err <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: table of frames with expected responses, scoreboard
// queues checked by a monitor, plus hand-written reset sequences.
module tb_spi_ram_ctrl;

   logic       clk;
   logic       rst_n;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       cmd_err;

   int cyc   = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [9:0] frame;
      int         hold;
      bit         exp_err;
      bit         exp_tx;
      logic [7:0] exp_data;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   vec_t vecs[$];
   exp_t tx_q[$];
   exp_t err_q[$];

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .cmd_err  (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [9:0] frame, input int hold, input bit e_err,
                      input bit e_tx, input logic [7:0] e_data);
      vec_t v;
      v.frame    = frame;
      v.hold     = hold;
      v.exp_err  = e_err;
      v.exp_tx   = e_tx;
      v.exp_data = e_data;
      vecs.push_back(v);
   endtask

   // Called at a negedge; the following posedge is the accept edge.
   task automatic send(input vec_t v);
      exp_t e;
      rx_data  = v.frame;
      rx_valid = 1'b1;
      if (v.exp_err) begin
         e.data = 8'h00;
         e.due  = cyc + 1;
         err_q.push_back(e);
      end
      if (v.exp_tx) begin
         e.data = v.exp_data;
         e.due  = cyc + 2;
         tx_q.push_back(e);
      end
      @(negedge clk);
      // Payload changes while held must not be seen.
      if (v.hold > 1) rx_data = 10'h1EE;
      repeat (v.hold - 1) @(negedge clk);
      rx_valid = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (tx_valid === 1'b1) begin
         n_vec++;
         if (tx_q.size() == 0) begin
            n_err++;
            $display("FAIL tx_valid: unexpected pulse at cycle %0d with tx_data=%h, required none", cyc, tx_data);
         end else begin
            e = tx_q.pop_front();
            if (tx_data !== e.data || cyc != e.due) begin
               n_err++;
               $display("FAIL tx_data: got %h at cycle %0d, required %h at cycle %0d", tx_data, cyc, e.data, e.due);
            end
         end
      end else if (tx_q.size() > 0 && tx_q[0].due <= cyc) begin
         e = tx_q.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL tx_valid: no pulse by cycle %0d, required %h at cycle %0d", cyc, e.data, e.due);
      end

      if (cmd_err === 1'b1) begin
         n_vec++;
         if (err_q.size() == 0) begin
            n_err++;
            $display("FAIL cmd_err: unexpected pulse at cycle %0d, required none", cyc);
         end else begin
            e = err_q.pop_front();
            if (cyc != e.due) begin
               n_err++;
               $display("FAIL cmd_err: pulse at cycle %0d, required at cycle %0d", cyc, e.due);
            end
         end
      end else if (err_q.size() > 0 && err_q[0].due <= cyc) begin
         e = err_q.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL cmd_err: no pulse by cycle %0d, required at cycle %0d", cyc, e.due);
      end
   end

   initial begin
      vec_t v;
      rst_n    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 10'h000;

      // Reset with no clock edge: outputs clear immediately.
      #2 rst_n = 1'b0;
      #1;
      check("reset tx_data",  {24'h0, tx_data},  32'h0);
      check("reset tx_valid", {31'h0, tx_valid}, 32'h0);
      check("reset cmd_err",  {31'h0, cmd_err},  32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // frame, hold, exp_err, exp_tx, exp_data
      add(10'h300, 1, 1'b1, 1'b0, 8'h00);   // RD_DATA with no address
      add(10'h030, 1, 1'b0, 1'b0, 8'h00);
      add(10'h13C, 1, 1'b0, 1'b0, 8'h00);   // mem[30]=3C
      add(10'h011, 1, 1'b0, 1'b0, 8'h00);
      add(10'h199, 1, 1'b0, 1'b0, 8'h00);   // mem[11]=99
      add(10'h005, 1, 1'b0, 1'b0, 8'h00);
      add(10'h1A5, 1, 1'b0, 1'b0, 8'h00);
      add(10'h205, 1, 1'b0, 1'b0, 8'h00);
      add(10'h300, 1, 1'b0, 1'b1, 8'hA5);
      add(10'h0FF, 1, 1'b0, 1'b0, 8'h00);
      add(10'h111, 1, 1'b0, 1'b0, 8'h00);
      add(10'h122, 1, 1'b0, 1'b0, 8'h00);   // wraps to mem[00]
      add(10'h2FF, 1, 1'b0, 1'b0, 8'h00);
      add(10'h300, 1, 1'b0, 1'b1, 8'h11);
      add(10'h300, 1, 1'b0, 1'b1, 8'h22);
      add(10'h010, 1, 1'b0, 1'b0, 8'h00);
      add(10'h177, 5, 1'b0, 1'b0, 8'h00);   // held level: one write only
      add(10'h210, 1, 1'b0, 1'b0, 8'h00);
      add(10'h300, 1, 1'b0, 1'b1, 8'h77);
      add(10'h300, 1, 1'b0, 1'b1, 8'h99);
      add(10'h020, 1, 1'b0, 1'b0, 8'h00);
      add(10'h230, 1, 1'b0, 1'b0, 8'h00);
      add(10'h1CC, 1, 1'b0, 1'b0, 8'h00);
      add(10'h300, 1, 1'b0, 1'b1, 8'h3C);
      add(10'h220, 1, 1'b0, 1'b1 ^ 1'b1, 8'h00);
      add(10'h300, 1, 1'b0, 1'b1, 8'hCC);
      add(10'h000, 1, 1'b0, 1'b0, 8'h00);
      add(10'h15A, 1, 1'b0, 1'b0, 8'h00);   // mem[00]=5A

      foreach (vecs[i]) send(vecs[i]);

      check("tx_data held", {24'h0, tx_data}, 32'h0000_00CC);

      // Reset while a read sits in the pipeline.
      rx_data  = 10'h300;
      rx_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid-read reset tx_valid", {31'h0, tx_valid}, 32'h0);
      check("mid-read reset tx_data",  {24'h0, tx_data},  32'h0);
      rx_data = 10'h200;                    // still high at release: RD_ADDR 00
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("tx_data after reset", {24'h0, tx_data}, 32'h0);

      v.frame = 10'h1EE; v.hold = 1; v.exp_err = 1'b1; v.exp_tx = 1'b0; v.exp_data = 8'h00;
      send(v);                              // no WR_ADDR since reset
      v.frame = 10'h300; v.hold = 1; v.exp_err = 1'b0; v.exp_tx = 1'b1; v.exp_data = 8'h5A;
      send(v);                              // mem[00] unchanged
      repeat (5) @(negedge clk);

      check("tx scoreboard drained",  tx_q.size(),  32'h0);
      check("err scoreboard drained", err_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
